dynamic_bpredictor: RTL
=======================

// Module: dynamic_bpredictor
// PURPOSE
//  Parametrised dynamic branch predictor for the PQR5 Fetch Unit (FU); replaces the static BTFN predictor.
//  Branch History Table (BHT) of 2-bit saturating counters, indexed by PC (bimodal) or PC^GHR (gshare).
//  Zero-cycle combinational lookup for the FU's current instruction.
//  Synchronous training port driven by EXU branch resolution.
//  MODE=0 keeps static behaviour: JAL taken, branch taken iff backward.
// PARAMETERS
//  XLEN       32  datapath/PC width
//  BHT_IDX_W  6   BHT index width; BHT depth = 2**BHT_IDX_W entries
//  GHR_W      0   global history bits XORed into index; 0 = pure bimodal; must be <= BHT_IDX_W
//  BHT_INIT   2'b01  counter reset value (01 = weakly not-taken)
//  MODE       1   0 = static BTFN (BHT/GHR unused, held at reset), 1 = dynamic
// PORTS
//  clk             in   1          core clock, all state on rising edge
//  srstn           in   1          synchronous active-low reset
//  i_is_op_jal     in   1          current FU instr is JAL
//  i_is_op_branch  in   1          current FU instr is conditional branch
//  i_immJ          in   XLEN       sign-extended J immediate
//  i_immB          in   XLEN       sign-extended B immediate
//  i_instr_valid   in   1          FU instr valid
//  i_pc            in   XLEN       PC of FU instr
//  o_branch_pc     out  XLEN       predicted target = i_pc + offset
//  o_branch_taken  out  1          prediction; 1 = redirect fetch to o_branch_pc
//  o_pred_idx      out  BHT_IDX_W  BHT index used for this lookup; piped with instr to EXU
//  i_upd_valid     in   1          EXU resolved a conditional branch this cycle
//  i_upd_idx       in   BHT_IDX_W  o_pred_idx carried with the resolved branch
//  i_upd_taken     in   1          actual outcome; 1 = taken
// BEHAVIOUR
//  - Index: idx = i_pc[BHT_IDX_W+1:2] ^ {{(BHT_IDX_W-GHR_W){1'b0}}, ghr}. PC[1:0] ignored.
//    When GHR_W=0: idx = i_pc[BHT_IDX_W+1:2].
//  - Offset: immJ if JAL, else immB if branch, else 0. JAL has priority.
//    o_branch_pc = i_pc + offset, modulo 2**XLEN (wraps, no overflow flag).
//  - o_branch_taken, MODE=1:
//      i_instr_valid & (jal | (branch & bht[idx][1])) & srstn.
//  - o_branch_taken, MODE=0:
//      i_instr_valid & (jal | (branch & i_immB[XLEN-1])) & srstn.
//  - o_pred_idx is always driven, irrespective of valid.
//  - Reset (srstn=0 at clk edge): all BHT entries <= BHT_INIT; ghr <= 0.
//    While srstn=0, o_branch_taken is forced 0. o_branch_pc and o_pred_idx stay combinational.
//    A reset mid-training discards any in-flight update; the table returns to the all-BHT_INIT state.
//  - Training (MODE=1, i_upd_valid=1 at clk edge):
//      - bht[i_upd_idx] increments when i_upd_taken=1, saturating at 11.
//      - bht[i_upd_idx] decrements when i_upd_taken=0, saturating at 00.
//      - GHR_W>0: ghr <= {ghr[GHR_W-2:0], i_upd_taken}; for GHR_W=1, ghr <= i_upd_taken.
//      - JAL is never trained.
//  - Latency: lookup is 0-cycle combinational. An update is visible to lookups from the cycle after the edge.
//  - Same-cycle lookup and update to the same index: lookup returns the pre-update counter. No bypass.
//  - Only one update per cycle. MODE=0 ignores i_upd_*.
//  - Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T. Predict taken iff bit[1]=1.
// TESTING
//  1. Reset, MODE=1, BHT_INIT=01. Branch at pc=0x100, immB=-8, valid.
//     -> taken=0 (not static), branch_pc=0xF8, pred_idx=0x00.
//  2. Train idx 0x00 with taken=1 once.
//     -> next cycle same lookup: taken=1.
//     Train taken=1 x3 more, then taken=0 once -> still taken=1 (11 -> 10).
//  3. Saturation: 5x taken=0 on idx 5 -> counter 00.
//     One taken=1 -> 01, prediction still 0.
//  4. Same-cycle update/lookup, idx 3 at 01, upd_taken=1.
//     -> lookup that cycle taken=0; next cycle taken=1.
//  5. GHR_W=2: updates T,T -> ghr=11. Lookup pc=0x10 -> pred_idx=0x04^0x03=0x07.
//     Assert srstn=0 for 1 cycle -> ghr=0, all counters 01, taken=0 during reset.
//  6. MODE=0: JAL pc=0xFFFFFFFC, immJ=8 -> taken=1, branch_pc=0x4 (wrap).
//     Branch immB=+16 -> taken=0. i_instr_valid=0 -> taken=0.

Source files
------------

// File: rtl/dynamic_bpredictor.sv
// dynamic_bpredictor: bimodal/gshare 2-bit counter branch predictor with static BTFN fallback
module dynamic_bpredictor #(
  parameter int XLEN = 32,
  parameter int BHT_IDX_W = 6,
  parameter int GHR_W = 0,
  parameter logic [1:0] BHT_INIT = 2'b01,
  parameter int MODE = 1
) (
  input  logic                 clk,
  input  logic                 srstn,
  input  logic                 i_is_op_jal,
  input  logic                 i_is_op_branch,
  input  logic [XLEN-1:0]      i_immJ,
  input  logic [XLEN-1:0]      i_immB,
  input  logic                 i_instr_valid,
  input  logic [XLEN-1:0]      i_pc,
  output logic [XLEN-1:0]      o_branch_pc,
  output logic                 o_branch_taken,
  output logic [BHT_IDX_W-1:0] o_pred_idx,
  input  logic                 i_upd_valid,
  input  logic [BHT_IDX_W-1:0] i_upd_idx,
  input  logic                 i_upd_taken
);
  localparam int GW = GHR_W > 0 ? GHR_W : 1;
  logic [1:0] bht [2**BHT_IDX_W];
  logic [GW-1:0] ghr;
  logic [XLEN-1:0] offset;
  logic pred;
  logic [1:0] cnt;
  always_comb begin
    offset = i_is_op_jal ? i_immJ : i_is_op_branch ? i_immB : '0;
    o_branch_pc = i_pc + offset;
    o_pred_idx = i_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr);
    pred = MODE != 0 ? bht[o_pred_idx][1] : i_immB[XLEN-1];
    o_branch_taken = i_instr_valid & (i_is_op_jal | (i_is_op_branch & pred)) & srstn;
    cnt = bht[i_upd_idx];
  end
  // ghr stays zero when GHR_W=0, so the index degenerates to pure bimodal
  always_ff @(posedge clk) begin
    if (!srstn) begin
      for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= BHT_INIT;
      ghr <= '0;
    end else if (MODE != 0 && i_upd_valid) begin
      bht[i_upd_idx] <= i_upd_taken ? (&cnt ? 2'b11 : cnt + 2'd1) : (|cnt ? cnt - 2'd1 : 2'b00);
      if (GHR_W > 0) ghr <= GW'({ghr, i_upd_taken});
    end
  end
endmodule
